// File: rtl/pll_reset_sequencer.sv
// Purpose: sequence a PLL out of reset, wait for stable lock, and retry or give up on timeout.
// Latency: lock sampled at edge k reaches STABLE after edge k+2 and ready after edge k+2+LOCK_STABLE.
// Backpressure: none; the PLL and restart inputs are always accepted, and all outputs are registered.
module pll_reset_sequencer #(
  parameter int RST_PULSE    = 16,
  parameter int LOCK_STABLE  = 1024,
  parameter int LOCK_TIMEOUT = 100000,
  parameter int MAX_RETRIES  = 3,
  localparam int RW = ((MAX_RETRIES + 1) > 1) ? $clog2(MAX_RETRIES + 1) : 1
) (
  input  logic          refclk,
  input  logic          rst_n,
  input  logic          pll_locked,
  input  logic          restart,
  output logic          pll_rst,
  output logic          ready,
  output logic          fail,
  output logic [2:0]    state,
  output logic [RW-1:0] retry_cnt,
  output logic [7:0]    lock_loss_cnt
);

  localparam logic [2:0] S_RESET  = 3'd0;
  localparam logic [2:0] S_WAIT   = 3'd1;
  localparam logic [2:0] S_STABLE = 3'd2;
  localparam logic [2:0] S_RUN    = 3'd3;
  localparam logic [2:0] S_FAIL   = 3'd4;

  // One counter serves all timed states, so it must reach the longest interval.
  localparam int CMAX_A = (RST_PULSE > LOCK_STABLE) ? RST_PULSE : LOCK_STABLE;
  localparam int CMAX   = (CMAX_A > LOCK_TIMEOUT) ? CMAX_A : LOCK_TIMEOUT;
  localparam int CW     = $clog2(CMAX + 1);

  localparam logic [CW-1:0] RST_END     = CW'(RST_PULSE - 1);
  localparam logic [CW-1:0] STABLE_END  = CW'(LOCK_STABLE - 1);
  localparam logic [CW-1:0] TIMEOUT_END = CW'(LOCK_TIMEOUT - 1);
  localparam logic [RW-1:0] RETRY_MAX   = RW'(MAX_RETRIES);

  logic          sync1_q, sync2_q;
  logic [2:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [RW-1:0] retry_q, retry_d;
  logic [7:0]    loss_q, loss_d;
  logic          pll_rst_q, pll_rst_d;
  logic          ready_q, ready_d;
  logic          fail_q, fail_d;
  logic          locked_sync;

  assign locked_sync = sync2_q;

  // Two-flop synchronizer for the asynchronous lock flag.
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= pll_locked;
      sync2_q <= sync1_q;
    end
  end

  // Next-state, retry and lock-loss bookkeeping; restart overrides everything else.
  always_comb begin
    state_d = state_q;
    retry_d = retry_q;
    loss_d  = loss_q;
    if (restart) begin
      state_d = S_RESET;
      retry_d = '0;
    end else begin
      case (state_q)
        S_RESET: begin
          if (cnt_q == RST_END) state_d = S_WAIT;
        end
        S_WAIT: begin
          if (locked_sync) begin
            state_d = S_STABLE;
          end else if (cnt_q == TIMEOUT_END) begin
            if (retry_q < RETRY_MAX) begin
              retry_d = retry_q + 1'b1;
              state_d = S_RESET;
            end else begin
              state_d = S_FAIL;
            end
          end
        end
        S_STABLE: begin
          if (!locked_sync)              state_d = S_WAIT;
          else if (cnt_q == STABLE_END)  state_d = S_RUN;
        end
        S_RUN: begin
          if (!locked_sync) begin
            state_d = S_RESET;
            if (loss_q != 8'hFF) loss_d = loss_q + 1'b1;
          end
        end
        S_FAIL:  state_d = S_FAIL;
        default: state_d = S_RESET;
      endcase
      if (state_d == S_RUN && state_q != S_RUN) retry_d = '0;
    end
  end

  // Shared interval counter: cleared on any state entry (including a restart into RESET).
  always_comb begin
    cnt_d = '0;
    if (!restart && state_d == state_q &&
        (state_q == S_RESET || state_q == S_WAIT || state_q == S_STABLE)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Output flags are decoded from the next state so they change with the state register.
  always_comb begin
    pll_rst_d = (state_d == S_RESET) || (state_d == S_FAIL);
    ready_d   = (state_d == S_RUN);
    fail_d    = (state_d == S_FAIL);
  end

  // State, counters and registered outputs.
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_RESET;
      cnt_q     <= '0;
      retry_q   <= '0;
      loss_q    <= '0;
      pll_rst_q <= 1'b1;
      ready_q   <= 1'b0;
      fail_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      retry_q   <= retry_d;
      loss_q    <= loss_d;
      pll_rst_q <= pll_rst_d;
      ready_q   <= ready_d;
      fail_q    <= fail_d;
    end
  end

  assign pll_rst       = pll_rst_q;
  assign ready         = ready_q;
  assign fail          = fail_q;
  assign state         = state_q;
  assign retry_cnt     = retry_q;
  assign lock_loss_cnt = loss_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Bench for pll_reset_sequencer: vector table, hand-written corner sequences, then random lock traffic
// checked against a timestamp-based reference model.
module tb_pll_reset_sequencer;

  localparam int RP = 4;
  localparam int LS = 8;
  localparam int LT = 50;
  localparam int MR = 2;

  logic       refclk;
  logic       rst_n;
  logic       pll_locked;
  logic       restart;
  logic       pll_rst;
  logic       ready;
  logic       fail;
  logic [2:0] state;
  logic [1:0] retry_cnt;
  logic [7:0] lock_loss_cnt;

  int n_chk = 0;
  int n_err = 0;

  pll_reset_sequencer #(
    .RST_PULSE(RP), .LOCK_STABLE(LS), .LOCK_TIMEOUT(LT), .MAX_RETRIES(MR)
  ) dut (
    .refclk(refclk), .rst_n(rst_n), .pll_locked(pll_locked), .restart(restart),
    .pll_rst(pll_rst), .ready(ready), .fail(fail), .state(state),
    .retry_cnt(retry_cnt), .lock_loss_cnt(lock_loss_cnt)
  );

  initial refclk = 1'b0;
  always #5 refclk = ~refclk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", n_err);
    $fatal(1, "watchdog");
  end

  // ---------------- reference model (time stamps + input history) ----------------
  int         m_e;
  int         m_entry;
  int         m_retry;
  int         m_loss;
  logic [2:0] m_st;
  bit         m_lk_q[$];

  task automatic model_reset();
    m_e = 0; m_entry = -1; m_st = 3'd0; m_retry = 0; m_loss = 0;
    m_lk_q.delete();
  endtask

  task automatic model_step(input bit lk, input bit rs);
    bit         ls;
    int         tin;
    logic [2:0] nxt;
    ls  = (m_lk_q.size() >= 2) ? m_lk_q[m_lk_q.size() - 2] : 1'b0;
    tin = m_e - m_entry;
    nxt = m_st;
    if (rs) begin
      nxt = 3'd0; m_retry = 0;
    end else begin
      case (m_st)
        3'd0: if (tin == RP) nxt = 3'd1;
        3'd1: begin
          if (ls) nxt = 3'd2;
          else if (tin == LT) begin
            if (m_retry < MR) begin m_retry++; nxt = 3'd0; end
            else nxt = 3'd4;
          end
        end
        3'd2: begin
          if (!ls) nxt = 3'd1;
          else if (tin == LS) begin nxt = 3'd3; m_retry = 0; end
        end
        3'd3: if (!ls) begin nxt = 3'd0; if (m_loss < 255) m_loss++; end
        default: nxt = m_st;
      endcase
    end
    if (rs || nxt != m_st) m_entry = m_e;
    m_st = nxt;
    m_lk_q.push_back(lk);
    if (m_lk_q.size() > 4) void'(m_lk_q.pop_front());
    m_e++;
  endtask

  function automatic logic [31:0] model_vec();
    logic [1:0] r;
    logic [7:0] l;
    r = m_retry[1:0];
    l = m_loss[7:0];
    return {16'd0, m_st, m_st == 3'd3, m_st == 3'd4, (m_st == 3'd0) || (m_st == 3'd4), r, l};
  endfunction

  function automatic logic [31:0] dut_vec();
    return {16'd0, state, ready, fail, pll_rst, retry_cnt, lock_loss_cnt};
  endfunction

  // ---------------- helpers ----------------
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge refclk);
    model_step(pll_locked, restart);
    @(negedge refclk);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic pulse_restart(input logic lk);
    pll_locked = lk;
    restart = 1'b1;
    tick();
    restart = 1'b0;
  endtask

  task automatic wait_ready(input logic v, input int bound, input string nm);
    int k;
    k = 0;
    while (ready !== v && k < bound) begin tick(); k++; end
    chk(nm, {31'd0, ready}, {31'd0, v});
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic       rs;
    logic       lk;
    int         n;
    logic [2:0] st;
    logic       rdy;
    logic       fl;
    logic       pr;
    logic [1:0] rt;
    logic [7:0] ll;
  } vec_t;

  vec_t tbl[21];

  initial begin
    //            rs lk  n    st   rdy fl pr retry ll
    tbl[0]  = '{1'b0, 1'b0,  3, 3'd0, 1'b0, 1'b0, 1'b1, 2'd0, 8'd0};  // pulse still high
    tbl[1]  = '{1'b0, 1'b0,  1, 3'd1, 1'b0, 1'b0, 1'b0, 2'd0, 8'd0};  // pll_rst falls
    tbl[2]  = '{1'b0, 1'b0, 49, 3'd1, 1'b0, 1'b0, 1'b0, 2'd0, 8'd0};  // one short of timeout
    tbl[3]  = '{1'b0, 1'b0,  1, 3'd0, 1'b0, 1'b0, 1'b1, 2'd1, 8'd0};  // retry 1
    tbl[4]  = '{1'b0, 1'b0,  3, 3'd0, 1'b0, 1'b0, 1'b1, 2'd1, 8'd0};
    tbl[5]  = '{1'b0, 1'b0,  1, 3'd1, 1'b0, 1'b0, 1'b0, 2'd1, 8'd0};
    tbl[6]  = '{1'b0, 1'b0, 50, 3'd0, 1'b0, 1'b0, 1'b1, 2'd2, 8'd0};  // retry 2
    tbl[7]  = '{1'b0, 1'b0,  4, 3'd1, 1'b0, 1'b0, 1'b0, 2'd2, 8'd0};
    tbl[8]  = '{1'b0, 1'b0, 49, 3'd1, 1'b0, 1'b0, 1'b0, 2'd2, 8'd0};
    tbl[9]  = '{1'b0, 1'b0,  1, 3'd4, 1'b0, 1'b1, 1'b1, 2'd2, 8'd0};  // exhausted
    tbl[10] = '{1'b0, 1'b0, 20, 3'd4, 1'b0, 1'b1, 1'b1, 2'd2, 8'd0};  // terminal
    tbl[11] = '{1'b1, 1'b0,  1, 3'd0, 1'b0, 1'b0, 1'b1, 2'd0, 8'd0};  // restart out of FAIL
    tbl[12] = '{1'b0, 1'b1,  4, 3'd1, 1'b0, 1'b0, 1'b0, 2'd0, 8'd0};
    tbl[13] = '{1'b0, 1'b1,  1, 3'd2, 1'b0, 1'b0, 1'b0, 2'd0, 8'd0};
    tbl[14] = '{1'b0, 1'b1,  7, 3'd2, 1'b0, 1'b0, 1'b0, 2'd0, 8'd0};
    tbl[15] = '{1'b0, 1'b1,  1, 3'd3, 1'b1, 1'b0, 1'b0, 2'd0, 8'd0};  // ready
    tbl[16] = '{1'b0, 1'b0,  1, 3'd3, 1'b1, 1'b0, 1'b0, 2'd0, 8'd0};  // lock drops
    tbl[17] = '{1'b0, 1'b1,  1, 3'd3, 1'b1, 1'b0, 1'b0, 2'd0, 8'd0};
    tbl[18] = '{1'b0, 1'b1,  1, 3'd0, 1'b0, 1'b0, 1'b1, 2'd0, 8'd1};  // loss seen 3 edges later
    tbl[19] = '{1'b0, 1'b1, 12, 3'd2, 1'b0, 1'b0, 1'b0, 2'd0, 8'd1};
    tbl[20] = '{1'b0, 1'b1,  1, 3'd3, 1'b1, 1'b0, 1'b0, 2'd0, 8'd1};  // sequence repeated
  end

  // ---------------- main test ----------------
  initial begin
    int run;
    bit lvl;
    rst_n = 1'b0; pll_locked = 1'b0; restart = 1'b0;
    model_reset();
    repeat (3) @(negedge refclk);

    chk("rst_state",   {29'd0, state},   32'd0);
    chk("rst_pll_rst", {31'd0, pll_rst}, 32'd1);
    chk("rst_ready",   {31'd0, ready},   32'd0);
    chk("rst_fail",    {31'd0, fail},    32'd0);
    chk("rst_retry",   {30'd0, retry_cnt}, 32'd0);
    chk("rst_loss",    {24'd0, lock_loss_cnt}, 32'd0);

    rst_n = 1'b1;

    for (int r = 0; r < 21; r++) begin
      pll_locked = tbl[r].lk;
      restart    = tbl[r].rs;
      for (int i = 0; i < tbl[r].n; i++) begin
        tick();
        restart = 1'b0;
      end
      chk($sformatf("row%0d_state", r),   {29'd0, state},         {29'd0, tbl[r].st});
      chk($sformatf("row%0d_ready", r),   {31'd0, ready},         {31'd0, tbl[r].rdy});
      chk($sformatf("row%0d_fail", r),    {31'd0, fail},          {31'd0, tbl[r].fl});
      chk($sformatf("row%0d_pll_rst", r), {31'd0, pll_rst},       {31'd0, tbl[r].pr});
      chk($sformatf("row%0d_retry", r),   {30'd0, retry_cnt},     {30'd0, tbl[r].rt});
      chk($sformatf("row%0d_loss", r),    {24'd0, lock_loss_cnt}, {24'd0, tbl[r].ll});
    end

    // Lock glitch while STABLE counter is at 5: back to WAIT_LOCK, no lock-loss count.
    pulse_restart(1'b1);
    chk("glitch_restart_state", {29'd0, state}, 32'd0);
    chk("glitch_loss_kept", {24'd0, lock_loss_cnt}, 32'd1);
    ticks(8);
    chk("glitch_in_stable", {29'd0, state}, 32'd2);
    pll_locked = 1'b0; tick();
    pll_locked = 1'b1; tick();
    chk("glitch_cnt5_state", {29'd0, state}, 32'd2);
    tick();
    chk("glitch_back_wait", {29'd0, state}, 32'd1);
    tick();
    chk("glitch_restable", {29'd0, state}, 32'd2);
    ticks(7);
    chk("glitch_not_ready", {31'd0, ready}, 32'd0);
    tick();
    chk("glitch_ready", {31'd0, ready}, 32'd1);
    chk("glitch_loss", {24'd0, lock_loss_cnt}, 32'd1);

    // Restart on the very edge the WAIT_LOCK timeout would fire.
    pulse_restart(1'b0);
    chk("rto_state0", {29'd0, state}, 32'd0);
    ticks(4);
    chk("rto_wait", {29'd0, state}, 32'd1);
    ticks(49);
    chk("rto_prewait", {29'd0, state}, 32'd1);
    pulse_restart(1'b0);
    chk("rto_state", {29'd0, state}, 32'd0);
    chk("rto_retry", {30'd0, retry_cnt}, 32'd0);
    chk("rto_fail",  {31'd0, fail}, 32'd0);
    ticks(54);
    chk("rto_real_timeout_state", {29'd0, state}, 32'd0);
    chk("rto_real_timeout_retry", {30'd0, retry_cnt}, 32'd1);

    // Lock-loss counter saturation over 300 losses.
    pulse_restart(1'b1);
    wait_ready(1'b1, 40, "sat_first_ready");
    for (int i = 0; i < 300; i++) begin
      pll_locked = 1'b0; tick();
      pll_locked = 1'b1;
      wait_ready(1'b0, 10, "sat_drop");
      wait_ready(1'b1, 40, "sat_relock");
    end
    chk("sat_loss", {24'd0, lock_loss_cnt}, 32'd255);
    pulse_restart(1'b1);
    chk("sat_restart_keeps_loss", {24'd0, lock_loss_cnt}, 32'd255);
    wait_ready(1'b1, 40, "sat_ready_again");

    // Asynchronous reset between clock edges while running.
    #1 rst_n = 1'b0;
    model_reset();
    #1;
    chk("arst_ready",   {31'd0, ready},   32'd0);
    chk("arst_pll_rst", {31'd0, pll_rst}, 32'd1);
    chk("arst_state",   {29'd0, state},   32'd0);
    chk("arst_loss",    {24'd0, lock_loss_cnt}, 32'd0);
    @(negedge refclk);
    rst_n = 1'b1;

    // Random lock traffic and occasional restarts against the model.
    run = 0; lvl = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      if (run == 0) begin
        lvl = 1'($urandom_range(0, 1));
        run = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : int'($urandom_range(10, 90));
      end
      run--;
      pll_locked = lvl;
      restart = ($urandom_range(0, 199) == 0);
      tick();
      chk($sformatf("rand_c%0d", c), dut_vec(), model_vec());
    end
    restart = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/pll_reset_sequencer.md
PLL_RESET_SEQUENCER -- requirements
Module: pll_reset_sequencer

Interface
REQ-001 SHALL have parameter RST_PULSE, default 16: pll_rst high-time in refclk cycles per attempt (>=2).
REQ-002 SHALL have parameter LOCK_STABLE, default 1024: consecutive synchronized-lock cycles required before ready (>=1).
REQ-003 SHALL have parameter LOCK_TIMEOUT, default 100000: refclk cycles to wait for lock per attempt (1 ms at 100 MHz).
REQ-004 SHALL have parameter MAX_RETRIES, default 3: re-attempts after the first before fail; total attempts = MAX_RETRIES+1.
REQ-005 SHALL have port refclk, input, 1: free-running reference clock; the single clock of this block, rising-edge.
REQ-006 SHALL have port rst_n, input, 1: asynchronous active-low reset.
REQ-007 SHALL have port pll_locked, input, 1: PLL lock flag; asynchronous to refclk.
REQ-008 SHALL have port restart, input, 1: synchronous single-cycle request to re-run the sequence.
REQ-009 SHALL have port pll_rst, output, 1: active-high reset driven to the PLL.
REQ-010 SHALL have port ready, output, 1: high = PLL output clock usable, downstream may leave reset.
REQ-011 SHALL have port fail, output, 1: high = all attempts exhausted.
REQ-012 SHALL have port state, output, 3: current FSM encoding (RESET=0, WAIT_LOCK=1, STABLE=2, RUN=3, FAIL=4).
REQ-013 SHALL have port retry_cnt, output, clog2(MAX_RETRIES+1) (min 1): re-attempts used in current sequence.
REQ-014 SHALL have port lock_loss_cnt, output, 8: count of lock losses seen in RUN.

Function
REQ-015 SHALL synchronize pll_locked through exactly two refclk flops; locked_sync is pll_locked delayed two edges; no other logic SHALL use raw pll_locked.
REQ-016 SHALL use one shared cycle counter sized for max(RST_PULSE, LOCK_STABLE, LOCK_TIMEOUT), cleared on every state entry.
REQ-017 RESET: pll_rst=1; after RST_PULSE cycles in state -> WAIT_LOCK.
REQ-018 WAIT_LOCK: pll_rst=0; locked_sync=1 -> STABLE; else on counter==LOCK_TIMEOUT-1: retry_cnt<MAX_RETRIES -> retry_cnt+1, RESET; retry_cnt==MAX_RETRIES -> FAIL.
REQ-019 STABLE: counter increments per cycle; locked_sync=0 -> WAIT_LOCK (timeout counter restarts); counter==LOCK_STABLE-1 with locked_sync=1 -> RUN.
REQ-020 RUN: ready=1, retry_cnt cleared on entry; locked_sync=0 -> RESET and lock_loss_cnt+1, saturating at 255.
REQ-021 FAIL: fail=1, pll_rst=1 held, ready=0; terminal until restart or rst_n.
REQ-022 restart=1 SHALL force RESET from any state on next edge, clear retry_cnt, clear fail; lock_loss_cnt preserved.
REQ-023 Priority SHALL be rst_n > restart > timeout/lock-loss > normal transitions; restart in RESET restarts the pulse count.
REQ-024 All outputs SHALL be registered; ready=1 iff state==RUN; fail=1 iff state==FAIL; pll_rst=1 iff state in {RESET, FAIL}.
REQ-025 Latency: pll_locked first sampled high at edge k in WAIT_LOCK -> STABLE after edge k+2 -> ready high after edge k+2+LOCK_STABLE.

Reset
REQ-026 While rst_n=0: state=RESET, pll_rst=1, ready=0, fail=0, retry_cnt=0, lock_loss_cnt=0, sync flops=0, counter=0.
REQ-027 rst_n assertion mid-operation SHALL immediately drop ready and raise pll_rst, independent of refclk.
REQ-028 First edge with rst_n=1 is cycle 0 of RESET; pll_rst falls after edge RST_PULSE.

Verification (RST_PULSE=4, LOCK_STABLE=8, LOCK_TIMEOUT=50, MAX_RETRIES=2)
REQ-029 Release rst_n, pll_locked rises 10 cycles later -> pll_rst high 4 cycles, ready rises 10 cycles after first sampled lock, retry_cnt=0.
REQ-030 pll_locked held 0 -> three pll_rst pulses of 4 cycles, 50-cycle waits, retry_cnt 0->1->2, then fail=1, state=4, pll_rst=1.
REQ-031 In RUN, pll_locked drops 1 cycle -> ready falls 3 edges later, state=RESET, lock_loss_cnt=1, full sequence repeats.
REQ-032 In STABLE, 1-cycle lock glitch at counter=5 -> return to WAIT_LOCK, ready delayed; no lock_loss_cnt increment.
REQ-033 restart pulse in FAIL and same-cycle timeout in WAIT_LOCK -> RESET, fail=0, retry_cnt=0; 300 lock losses -> lock_loss_cnt=255.
